// File: rtl/frame_state_buffer.sv
// Double-buffered board-state memory feeding the VGA top level. The game writes the back bank,
// the display reads the front bank, and banks swap only on a VSync falling edge.
module frame_state_buffer #(
  parameter int                ADDR_W    = 10,
  parameter int                DATA_W    = 16,
  parameter int                SCORE_W   = 10,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               re,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [DATA_W-1:0]  state,
  input  logic               vsync,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [DATA_W-1:0]  wdata,
  input  logic               commit,
  input  logic               clear,
  input  logic [SCORE_W-1:0] score_in,
  output logic [SCORE_W-1:0] score,
  output logic               ready,
  output logic               frame_tick,
  output logic               front_sel
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] CLEAR     = 2'd1;
  localparam logic [1:0] WAIT_SWAP = 2'd2;

  logic [1:0]         fsm;
  logic               vsync_d;
  logic               fe;
  logic [ADDR_W-1:0]  cnt;
  logic [SCORE_W-1:0] score_pending;

  logic [DATA_W-1:0]  bank0 [DEPTH];
  logic [DATA_W-1:0]  bank1 [DEPTH];

  logic               mem_we;
  logic [ADDR_W-1:0]  mem_waddr;
  logic [DATA_W-1:0]  mem_wdata;

  assign fe    = vsync_d & ~vsync;
  assign ready = (fsm == IDLE);

  // Single write port into the back bank, shared by the writer and the clear engine.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = waddr;
    mem_wdata = wdata;
    if (fsm == IDLE && wr_en) begin
      mem_we = 1'b1;
    end else if (fsm == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = cnt;
      mem_wdata = CLEAR_VAL;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      if (front_sel) bank0[mem_waddr] <= mem_wdata;
      else           bank1[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= '0;
    end else if (re) begin
      state <= front_sel ? bank1[raddr] : bank0[raddr];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm           <= IDLE;
      front_sel     <= 1'b0;
      score         <= '0;
      frame_tick    <= 1'b0;
      vsync_d       <= 1'b1;
      cnt           <= '0;
      score_pending <= '0;
    end else begin
      vsync_d    <= vsync;
      frame_tick <= fe;
      case (fsm)
        IDLE: begin
          if (clear) begin
            fsm <= CLEAR;
          end else if (commit) begin
            fsm           <= WAIT_SWAP;
            score_pending <= score_in;
          end
        end
        CLEAR: begin
          cnt <= cnt + {{(ADDR_W-1){1'b0}}, 1'b1};
          if (cnt == {ADDR_W{1'b1}}) fsm <= IDLE;
        end
        WAIT_SWAP: begin
          // A commit taken on an fe edge lands here after that edge, so it waits a full frame.
          if (fe) begin
            front_sel <= ~front_sel;
            score     <= score_pending;
            fsm       <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/frame_state_buffer.md
Name: frame_state_buffer

Overview:
- Double-buffered board-state memory directly upstream of the VGA top level.
- Game logic writes a new board into the back bank. The VGA side reads the front bank through re/raddr and receives state.
- A commit request swaps banks and latches the new score at the next frame boundary (VSync falling edge), so the display never shows a half-updated board.
- A built-in clear engine fills the back bank with a constant.

Parameters:
- ADDR_W, 10: address width; each bank holds 2^ADDR_W words.
- DATA_W, 16: state word width.
- SCORE_W, 10: score width.
- CLEAR_VAL, 16'h0000: word written to every back-bank location by a clear.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- re  in  1  VGA read enable.
- raddr  in  ADDR_W  VGA read address (front bank).
- state  out  DATA_W  read data for raddr, one cycle after re.
- vsync  in  1  VSync from the transmitter, active-low pulse, same clock domain.
- wr_en  in  1  back-bank write strobe.
- waddr  in  ADDR_W  back-bank write address.
- wdata  in  DATA_W  back-bank write data.
- commit  in  1  request a bank swap at the next frame boundary.
- clear  in  1  request a fill of the back bank with CLEAR_VAL.
- score_in  in  SCORE_W  score to publish with the commit.
- score  out  SCORE_W  score associated with the displayed (front) bank.
- ready  out  1  high only in IDLE; wr_en/commit/clear are accepted only when ready=1.
- frame_tick  out  1  one-cycle pulse on every VSync falling edge.
- front_sel  out  1  index of the bank currently displayed.

Behaviour:
- Reset (reset=0, asynchronous):
  - fsm=IDLE, front_sel=0, state=0, score=0, ready=1, frame_tick=0.
  - Edge-detect register vsync_d=1; clear counter=0; score_pending=0.
  - Memory contents are not reset.
- Read path:
  - re=1 at cycle N → state at N+1 = bank[front_sel][raddr], using the front_sel value sampled at N.
  - re=0 → state holds its value.
  - Reads never stall and ignore the FSM.
- Frame edge: fe = vsync_d & ~vsync; vsync_d <= vsync every cycle. frame_tick is registered, so it is high the cycle after fe.
- FSM states IDLE, CLEAR, WAIT_SWAP:
  - IDLE, wr_en=1: write bank[~front_sel][waddr] <= wdata this edge.
  - IDLE, clear=1 → CLEAR:
    - clear has priority; a simultaneous commit is dropped.
    - A simultaneous wr_en is still performed, then overwritten by the clear.
  - IDLE, commit=1 (clear=0) → WAIT_SWAP; score_pending <= score_in.
    - A simultaneous wr_en lands before the swap.
  - CLEAR: writes CLEAR_VAL to bank[~front_sel][cnt] and increments cnt each cycle.
    - Runs 2^ADDR_W cycles; on cnt = all-ones the counter wraps to 0 and the FSM goes to IDLE.
    - wr_en, commit and clear are ignored.
  - WAIT_SWAP: on fe, front_sel <= ~front_sel, score <= score_pending, FSM → IDLE.
    - The first cycle with ready=1 is the cycle after fe.
    - wr_en, clear and commit are ignored while waiting.
    - A commit registered in the same cycle as fe does not swap on that fe; it waits for the next one.
- After a swap the new back bank holds the board from two commits ago. The writer must rewrite every word or issue a clear.
- fe outside WAIT_SWAP: only frame_tick pulses; no other effect.
- ready is combinational from the FSM state: ready = (fsm==IDLE).
- Reset asserted mid-CLEAR or mid-WAIT_SWAP aborts the operation: front_sel returns to 0, the pending score is lost, and back-bank contents are partially written.
- Memory:
  - Two banks of 2^ADDR_W × DATA_W, one write port and one read port each, inferable as block RAM.
  - Reading and writing the same bank in the same cycle cannot occur, because the read bank is always ≠ the write bank.

Test Plan:
- Release reset; vsync=1 → ready=1, front_sel=0, state=0, score=0. Toggle vsync low → frame_tick high for exactly one cycle.
- Write waddr=5, wdata=16'hABCD; commit with score_in=42; drive vsync 1→0 after 10 cycles:
  - ready=0 until the cycle after fe, then front_sel=1 and score=42.
  - re=1, raddr=5 → state=16'hABCD one cycle later.
- Before the swap, read raddr=5 from the front bank → old value (0 after a prior clear). The back-bank write does not appear on state.
- Assert clear=1 and commit=1 in the same cycle:
  - ready is low for exactly 1024 cycles; no swap occurs on a following fe.
  - Every back-bank word reads CLEAR_VAL after a subsequent commit and swap.
- In WAIT_SWAP, assert wr_en to addr 7 with 16'h1234 → ignored; after the swap, address 7 does not read 16'h1234.
- Assert reset=0 at cycle 300 of a clear → all outputs are at reset values immediately (asynchronous). After release, ready=1 and front_sel=0.
